onchip_mem_stream_reader: RTL and testbench
===========================================

Name: onchip_mem_stream_reader

Overview:
- Avalon-MM read master for the 32-bit single-port on-chip memory (64K words, 16-bit word address, 1-cycle read latency).
- Sits directly upstream of the memory's s1 port. Fetches a contiguous block of words from base_addr and delivers them as a valid/ready stream to downstream pixel/DMA logic.
- Internal FIFO absorbs backpressure without losing in-flight read data.

Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 32, memory data width
- FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a transfer, honoured only when idle
- base_addr  in  ADDR_W  first word address, sampled on accepted start
- word_count  in  ADDR_W+1  number of words to read (0..65536), sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word is accepted downstream
- mem_address  out  ADDR_W  read address to memory
- mem_chipselect  out  1  read strobe; high only in issue cycles
- mem_clken  out  1  tied high
- mem_write  out  1  tied low
- mem_byteenable  out  DATA_W/8  tied all-ones
- mem_readdata  in  DATA_W  memory data, valid the cycle after chipselect
- out_data  out  DATA_W  stream data (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accept
- out_last  out  1  high with the final word of the transfer

Behaviour:
- Reset (asynchronous): state=IDLE. busy=0, done=0, mem_chipselect=0, mem_address=0. FIFO empty, so out_valid=0 and out_last=0. All counters 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE + start, word_count>0: latch address and remaining count, go to ISSUE.
  - IDLE + start, word_count==0: no memory access; done pulses the next cycle; busy stays 0.
  - ISSUE: when the last read is issued, go to DRAIN.
  - DRAIN: when the FIFO empties and no read is in flight, pulse done for 1 cycle and go to IDLE.
  - start outside IDLE is ignored.
- Issue rule: a read issues in a cycle when state==ISSUE and (fifo_count + inflight) < FIFO_DEPTH. inflight is 0 or 1.
  - On issue: mem_chipselect=1, mem_address=current address. The address then increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000), and remaining count decrements.
- Capture: mem_readdata is written to the FIFO exactly one cycle after each issue cycle, unconditionally. The credit rule guarantees space. A FIFO overflow is a design error and is checked by an assertion in the bench.
- Throughput: 1 word/clk sustained when out_ready is held high. First out_valid appears 2 cycles after the accepted start: cycle 1 issue, cycle 2 data registered into the FIFO.
- Stream: a word transfers when out_valid && out_ready. FIFO write and read in the same cycle leave the count unchanged, including when the FIFO is full (read frees a slot, write fills it).
- out_last is tagged on the FIFO entry corresponding to the final issued read.
- out_data is don't-care while out_valid=0.

Optional Feature:
- Macro: ONCHIP_READER_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort while busy: stop issuing immediately and flush FIFO contents; any in-flight read data is discarded on return.
  - Enter DRAIN, pulse done once inflight is 0 (at most 2 cycles after abort), return to IDLE.
  - out_last is not asserted for an aborted transfer.
  - abort in IDLE has no effect.
  - abort and start in the same idle cycle: start wins.
- Not defined: port absent; the transfer always runs to completion.

Test Plan:
- start, base=0x0010, count=4, out_ready=1 -> mem_address 0x10..0x13 on consecutive cycles; out_data = mem[0x10..0x13]; out_last only on the 4th word; done one cycle after the 4th accept.
- base=0xFFFE, count=4 -> addresses FFFE, FFFF, 0000, 0001; data in order, no gaps.
- count=20, out_ready=0 for first 30 cycles -> exactly 8 reads issued, then chipselect stays low; FIFO full, no overflow. Release ready -> all 20 words delivered in order.
- count=0 -> no chipselect ever; done pulses the cycle after start; busy stays 0.
- start pulsed while busy (count=6 in progress) -> ignored; exactly 6 words and 1 done.
- Reset asserted mid-transfer (after 3 of 10 words) -> outputs zero asynchronously. After release, a new start with base=0x0100, count=2 streams mem[0x100], mem[0x101] with no stale data.
- With ONCHIP_READER_ABORT_EN: abort 2 cycles into a count=16 transfer -> chipselect drops that cycle; out_valid low after flush; done within 2 cycles; out_last never asserted.

Source files
------------

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM block reader for on-chip RAM -> valid/ready stream; optional abort via ONCHIP_READER_ABORT_EN.
// Latency: first out_valid 2 cycles after accepted start, then 1 word/clk sustained.
// Backpressure: reads issue only while FIFO occupancy plus in-flight read is below FIFO_DEPTH.
module onchip_mem_stream_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
`ifdef ONCHIP_READER_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W:0]    remaining;
    logic               inflight;
    logic               inflight_last;
    logic               zero_done;

    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic               abort_hit;
    logic               accept_start;
    logic               last_issue;
    logic               issue;
    logic               push, pop;
    logic               drain_done;
    logic [CNT_W:0]     occupancy;

`ifdef ONCHIP_READER_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // In-flight read holds a FIFO slot so its return always has room.
    assign occupancy    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign accept_start = (state == IDLE) && start;
    assign issue        = (state == ISSUE) && (occupancy < DEPTH_C) && !abort_hit;
    assign last_issue   = issue && (remaining == (ADDR_W+1)'(1));
    assign push         = inflight && !abort_hit;
    assign pop          = out_valid && out_ready && !abort_hit;
    assign drain_done   = (state == DRAIN) && (fifo_count == '0) && !inflight;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (word_count != '0)) state_nxt = ISSUE;
            ISSUE:   if (abort_hit || last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
        end else begin
            state         <= state_nxt;
            zero_done     <= accept_start && (word_count == '0);
            inflight      <= issue;
            inflight_last <= last_issue;
            if (accept_start) begin
                addr      <= base_addr;
                remaining <= word_count;
            end else if (issue) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            if (abort_hit) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_readdata;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

    assign busy           = (state != IDLE);
    assign done           = drain_done || zero_done;
    assign mem_address    = addr;
    assign mem_chipselect = issue;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign out_valid      = (fifo_count != '0);
    assign out_data       = fifo_data[rd_ptr];
    assign out_last       = out_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader with a behavioural 1-cycle-latency RAM.
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] word_count = '0;
`ifdef ONCHIP_READER_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        busy, done, mem_chipselect, mem_clken, mem_write;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = '0;
    logic [31:0] out_data;
    logic        out_valid, out_last;
    logic        out_ready = 1'b0;

    onchip_mem_stream_reader #(.ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
`ifdef ONCHIP_READER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem_word(mem_address);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] cs_addrs [$];
    logic [31:0] rx_data [$];
    logic        rx_last [$];
    int done_cnt, done_cyc, last_acc_cyc, first_valid_cyc, busy_cnt, max_out;
    bit saw_last;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect) cs_addrs.push_back(mem_address);
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                last_acc_cyc = cyc;
            end
            if (out_last) saw_last = 1'b1;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
            if (cs_addrs.size() - rx_data.size() > max_out) max_out = cs_addrs.size() - rx_data.size();
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cs_addrs.delete(); rx_data.delete(); rx_last.delete();
        done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; first_valid_cyc = -1;
        busy_cnt = 0; max_out = 0; saw_last = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int t = 0; t < limit && done_cnt == 0; t++) @(negedge clk);
        if (done_cnt == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", limit);
        end
    endtask

    typedef struct {
        logic [15:0] base;
        logic [16:0] count;
        int          stall;
        int          exp_stall_reads;
        logic [15:0] exp_last_addr;
    } vec_t;

    task automatic run_case(input vec_t v);
        int start_cyc, stall_reads;
        logic [15:0] a;
        clear_mon();
        @(negedge clk);
        base_addr = v.base; word_count = v.count; start = 1'b1;
        out_ready = (v.stall == 0);
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (v.stall) @(negedge clk);
        stall_reads = cs_addrs.size();
        out_ready = 1'b1;
        wait_done(300);
        repeat (3) @(negedge clk);
        check("read_count", cs_addrs.size(), v.count);
        check("rx_count", rx_data.size(), v.count);
        check("last_addr", cs_addrs[cs_addrs.size()-1], v.exp_last_addr);
        for (int i = 0; i < cs_addrs.size(); i++) begin
            a = v.base + 16'(i);
            check("addr_seq", cs_addrs[i], a);
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            a = v.base + 16'(i);
            check("rx_data", rx_data[i], mem_word(a));
            check("rx_last", rx_last[i], (i == int'(v.count) - 1));
        end
        check("done_cnt", done_cnt, 1);
        check("done_after_last", done_cyc - last_acc_cyc, 1);
        check("no_overflow", max_out <= 8, 1);
        if (v.stall > 0) check("stall_reads", stall_reads, v.exp_stall_reads);
        else             check("first_valid_lat", first_valid_cyc - start_cyc, 2);
    endtask

    vec_t vecs [4];

    initial begin
        int sc;
        vecs[0] = '{16'h0010, 17'd4,  0,  0, 16'h0013};
        vecs[1] = '{16'hFFFE, 17'd4,  0,  0, 16'h0001};
        vecs[2] = '{16'h0020, 17'd20, 30, 8, 16'h0033};
        vecs[3] = '{16'h1234, 17'd1,  0,  0, 16'h1234};

        #3;
        check("reset_outputs", {busy, done, mem_chipselect, mem_address, out_valid, out_last}, '0);
        check("tie_offs", {mem_clken, mem_write, mem_byteenable}, {1'b1, 1'b0, 4'hF});
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run_case(vecs[i]);

        // Zero-length transfer: done next cycle, no memory access, never busy.
        clear_mon();
        @(negedge clk);
        base_addr = 16'h0500; word_count = 17'd0; start = 1'b1; out_ready = 1'b1;
        sc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("zero_reads", cs_addrs.size(), 0);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_done_cyc", done_cyc - sc, 0);
        check("zero_busy", busy_cnt, 0);

        // Second start while busy is ignored.
        clear_mon();
        @(negedge clk);
        base_addr = 16'h0040; word_count = 17'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        base_addr = 16'h0080; word_count = 17'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        repeat (6) @(negedge clk);
        check("busy_start_reads", cs_addrs.size(), 6);
        check("busy_start_rx", rx_data.size(), 6);
        check("busy_start_first", rx_data[0], mem_word(16'h0040));
        check("busy_start_final", rx_data[rx_data.size()-1], mem_word(16'h0045));
        check("busy_start_done", done_cnt, 1);

        // Reset in the middle of a transfer.
        clear_mon();
        @(negedge clk);
        base_addr = 16'h0200; word_count = 17'd10; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50 && rx_data.size() < 3; t++) @(negedge clk);
        check("pre_reset_rx", rx_data.size(), 3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {busy, done, mem_chipselect, mem_address, out_valid, out_last}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_case('{16'h0100, 17'd2, 0, 0, 16'h0101});

`ifdef ONCHIP_READER_ABORT_EN
        clear_mon();
        @(negedge clk);
        base_addr = 16'h0300; word_count = 17'd16; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        #1;
        check("abort_cs_drop", mem_chipselect, 1'b0);
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_flushed", out_valid, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_done", done_cnt, 1);
        check("abort_done_soon", (done_cyc >= 0) && (done_cyc - cyc >= -3), 1);
        check("abort_reads", cs_addrs.size(), 2);
        check("abort_no_last", saw_last, 1'b0);
        check("abort_idle", {busy, out_valid}, 2'b00);
        out_ready = 1'b1;
        run_case('{16'h0400, 17'd3, 0, 0, 16'h0402});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
